// File: rtl/neo_irq_ctrl.sv
// neo_irq_ctrl: 68k interrupt controller (levels 1-3).
// Latches VBlank (L1), timer (L2) and cold-boot (L3) requests and drives
// active-low IPL1/IPL0 from the highest pending level. It snoops the 68k bus
// for lower-byte writes to the IRQ acknowledge register.
//
// Bus snoop handshake: an ack is accepted on a rising edge when
// nAS=0, M68K_RW=0, nLDS=0, M68K_ADDR==ACK_ADDR and the snooper is armed.
// Accepting an ack disarms the snooper. It re-arms on any edge where nAS=1,
// so each bus cycle produces at most one ack.
//
// Optional feature macro: NEO_IRQ_SYNC_EN
//   defined   : VBLANK_IRQ/TIMER_IRQ pass a 2-flop synchronizer and a
//               rising-edge detector, so one request is made per input rise.
//   undefined : the inputs are already-synchronous pulses, and each high
//               sample sets the pending bit.
module neo_irq_ctrl #(
    parameter logic [22:0] ACK_ADDR      = 23'h1E0006,
    parameter bit          COLD_BOOT_IRQ = 1'b1
) (
    input  logic        CLK_68KCLK,
    input  logic        nRESET,
    input  logic        VBLANK_IRQ,
    input  logic        TIMER_IRQ,
    input  logic [22:0] M68K_ADDR,
    input  logic [15:0] M68K_DATA,
    input  logic        nAS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    output logic        IPL1,
    output logic        IPL0,
    output logic [2:0]  IRQ_PENDING
);

    localparam logic [2:0] PEND_RST = COLD_BOOT_IRQ ? 3'b100 : 3'b000;
    localparam logic [1:0] IPL_RST  = COLD_BOOT_IRQ ? 2'b00  : 2'b11;

    logic [2:0] pend_q, pend_d;
    logic [1:0] ipl_q, ipl_d;
    logic       ack_armed_q, ack_armed_d;
    logic       set_vb, set_tm;
    logic       ack_hit;
    logic [2:0] clr;

    // The ack register only decodes DATA[2:0]; the upper data bits are snooped but ignored.
    logic unused_data;
    assign unused_data = ^M68K_DATA[15:3];

`ifdef NEO_IRQ_SYNC_EN
    logic [2:0] vb_sync_q, tm_sync_q;

    // Two synchronizer flops followed by the edge-detect history flop, per input.
    always_ff @(posedge CLK_68KCLK) begin
        if (!nRESET) begin
            vb_sync_q <= 3'b000;
            tm_sync_q <= 3'b000;
        end else begin
            vb_sync_q <= {vb_sync_q[1:0], VBLANK_IRQ};
            tm_sync_q <= {tm_sync_q[1:0], TIMER_IRQ};
        end
    end

    assign set_vb = vb_sync_q[1] & ~vb_sync_q[2];
    assign set_tm = tm_sync_q[1] & ~tm_sync_q[2];
`else
    assign set_vb = VBLANK_IRQ;
    assign set_tm = TIMER_IRQ;
`endif

    // Decode an accepted ack, then build the next pending set and the matching IPL encoding.
    always_comb begin
        ack_hit = !nAS && !M68K_RW && !nLDS && (M68K_ADDR == ACK_ADDR) && ack_armed_q;
        clr     = 3'b000;
        if (ack_hit) begin
            clr = {M68K_DATA[0], M68K_DATA[1], M68K_DATA[2]};
        end
        // Set after clear, so a request that coincides with its own ack is not lost.
        pend_d = (pend_q & ~clr) | {1'b0, set_tm, set_vb};

        ack_armed_d = ack_armed_q;
        if (nAS) begin
            ack_armed_d = 1'b1;
        end else if (ack_hit) begin
            ack_armed_d = 1'b0;
        end

        if (pend_d[2]) begin
            ipl_d = 2'b00;
        end else if (pend_d[1]) begin
            ipl_d = 2'b01;
        end else if (pend_d[0]) begin
            ipl_d = 2'b10;
        end else begin
            ipl_d = 2'b11;
        end
    end

    // Pending flags, registered IPL and ack arming state.
    always_ff @(posedge CLK_68KCLK) begin
        if (!nRESET) begin
            pend_q      <= PEND_RST;
            ipl_q       <= IPL_RST;
            ack_armed_q <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            ipl_q       <= ipl_d;
            ack_armed_q <= ack_armed_d;
        end
    end

    assign IRQ_PENDING = pend_q;
    assign IPL1        = ipl_q[1];
    assign IPL0        = ipl_q[0];

endmodule

// File: tb/tb_neo_irq_ctrl.sv
// Bench for neo_irq_ctrl: directed scenarios and random bus traffic.
// A reference model predicts the outputs, and a monitor compares them.
module tb_neo_irq_ctrl;

    localparam logic [22:0] ACK = 23'h1E0006;
    localparam bit          COLD = 1'b1;

    logic        clk;
    logic        nreset;
    logic        vblank, timer;
    logic [22:0] addr;
    logic [15:0] data;
    logic        nas, nlds, rw;
    logic        ipl1, ipl0;
    logic [2:0]  pending;

    neo_irq_ctrl #(.ACK_ADDR(ACK), .COLD_BOOT_IRQ(COLD)) dut (
        .CLK_68KCLK (clk),
        .nRESET     (nreset),
        .VBLANK_IRQ (vblank),
        .TIMER_IRQ  (timer),
        .M68K_ADDR  (addr),
        .M68K_DATA  (data),
        .nAS        (nas),
        .nLDS       (nlds),
        .M68K_RW    (rw),
        .IPL1       (ipl1),
        .IPL0       (ipl0),
        .IRQ_PENDING(pending)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend[1:3];     // m_pend[n] = level n pending
    bit m_armed;
    bit h_vb[3];         // input sample history (sync build only)
    bit h_tm[3];

    logic [4:0] exp_q[$];   // {pend[2:0], ipl1, ipl0}
    int vectors    = 0;
    int miscompares = 0;

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit req1, req2, acc;
        int level;
        logic [1:0] ipl;
        logic [2:0] p;
        if (!nreset) begin
            m_pend[3] = COLD;
            m_pend[2] = 0;
            m_pend[1] = 0;
            m_armed   = 1;
            for (int i = 0; i < 3; i++) begin
                h_vb[i] = 0;
                h_tm[i] = 0;
            end
        end else begin
`ifdef NEO_IRQ_SYNC_EN
            // One request per rise, arriving three edges after the input goes high.
            req1 = h_vb[1] && !h_vb[2];
            req2 = h_tm[1] && !h_tm[2];
            h_vb[2] = h_vb[1]; h_vb[1] = h_vb[0]; h_vb[0] = vblank;
            h_tm[2] = h_tm[1]; h_tm[1] = h_tm[0]; h_tm[0] = timer;
`else
            req1 = vblank;
            req2 = timer;
`endif
            acc = (nas == 0) && (rw == 0) && (nlds == 0) && (addr == ACK) && m_armed;
            if (acc && data[0]) m_pend[3] = 0;
            if (acc && data[1]) m_pend[2] = 0;
            if (acc && data[2]) m_pend[1] = 0;
            if (req1) m_pend[1] = 1;
            if (req2) m_pend[2] = 1;
            if (nas) m_armed = 1;
            else if (acc) m_armed = 0;
        end
        level = 0;
        for (int n = 1; n <= 3; n++) if (m_pend[n]) level = n;
        ipl = ~(2'(level));
        p = {m_pend[3], m_pend[2], m_pend[1]};
        exp_q.push_back({p, ipl});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst_n, input logic vb, input logic tm,
                         input logic [22:0] a, input logic [15:0] d,
                         input logic as_n, input logic lds_n, input logic r);
        @(negedge clk);
        nreset = rst_n; vblank = vb; timer = tm;
        addr = a; data = d; nas = as_n; nlds = lds_n; rw = r;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 23'h0, 16'h0, 1, 1, 1);
    endtask

    // Single-cycle lower-byte write to the ack register, then bus release.
    task automatic ack_write(input logic [15:0] d);
        drive(1, 0, 0, ACK, d, 0, 0, 0);
        idle(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [4:0] exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            vectors++;
            if ({pending, ipl1, ipl0} !== exp) begin
                miscompares++;
                $display("FAIL irq_state vec %0d t=%0t: got pend=%b ipl=%b%b, want pend=%b ipl=%b%b",
                         vectors, $time, pending, ipl1, ipl0, exp[4:2], exp[1], exp[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        nreset = 0; vblank = 0; timer = 0; addr = '0; data = '0;
        nas = 1; nlds = 1; rw = 1;

        // Cold-boot reset, then acknowledge level 3.
        drive(0, 0, 0, 23'h0, 16'h0, 1, 1, 1);
        drive(0, 0, 0, 23'h0, 16'h0, 1, 1, 1);
        idle(1);
        ack_write(16'h0001);

        // A VBlank pulse, then its ack.
        drive(1, 1, 0, 23'h0, 16'h0, 1, 1, 1);
        idle(1);
        ack_write(16'h0004);

        // Both L1 and L2 pending, then acked from the top down.
        drive(1, 1, 0, 23'h0, 16'h0, 1, 1, 1);
        drive(1, 0, 1, 23'h0, 16'h0, 1, 1, 1);
        ack_write(16'h0002);
        ack_write(16'h0004);

        // A timer pulse on the same edge as its ack: the set wins.
        drive(1, 0, 1, ACK, 16'h0002, 0, 0, 0);
        idle(1);
        ack_write(16'h0002);

        // Ack held for 4 cycles with a timer pulse in cycle 2: only one ack is taken.
        drive(1, 0, 0, ACK, 16'h0002, 0, 0, 0);
        drive(1, 0, 1, ACK, 16'h0002, 0, 0, 0);
        drive(1, 0, 0, ACK, 16'h0002, 0, 0, 0);
        drive(1, 0, 0, ACK, 16'h0002, 0, 0, 0);
        idle(1);

        // An upper-byte-only write and a read of the ack address have no effect.
        drive(1, 0, 0, ACK, 16'h0007, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, ACK, 16'h0007, 0, 0, 1);
        idle(1);
        ack_write(16'h0007);

        // Reset in the middle of a bus cycle, then an ack while nAS is still low.
        drive(1, 1, 1, 23'h0, 16'h0, 1, 1, 1);
        drive(0, 0, 0, ACK, 16'h0001, 0, 0, 0);
        drive(1, 0, 0, ACK, 16'h0001, 0, 0, 0);
        idle(1);

        // Random traffic, biased toward the ack address.
        for (int i = 0; i < 3000; i++) begin
            logic [22:0] a;
            logic [15:0] d;
            a = ($urandom_range(0, 9) < 7) ? ACK : 23'($urandom);
            d = 16'($urandom);
            drive(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 15),
                  a, d,
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 25));
        end
        idle(2);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
